imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_W, default 10, width of the instruction-memory word index (1024 words).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 in_data  input  8  program-stream byte.
REQ-005 in_valid  input  1  in_data valid this cycle.
REQ-006 in_ready  output  1  loader accepts a byte this cycle; transfer = in_valid & in_ready.
REQ-007 clear  input  1  synchronous return from DONE/ERROR to IDLE.
REQ-008 mem_we  output  1  one-cycle instruction-memory write strobe.
REQ-009 mem_waddr  output  ADDR_W  word index written when mem_we=1.
REQ-010 mem_wdata  output  32  instruction word written when mem_we=1.
REQ-011 busy  output  1  frame in progress; the core is held in reset while busy=1.
REQ-012 done  output  1  frame loaded with matching checksum; held until clear.
REQ-013 error  output  1  frame rejected; held until clear.

Function
REQ-014 The frame format shall be: 4-byte start byte-address (little-endian), 2-byte word count N (little-endian), 4*N data bytes (each word little-endian), 1 checksum byte.
REQ-015 The checksum shall be the XOR of all 4*N data bytes; header bytes are excluded.
REQ-016 States shall be IDLE, ADDR, COUNT, DATA, CHECK, DONE, ERROR.
REQ-017 IDLE: the first accepted byte shall be address byte 0; go to ADDR; busy rises the cycle after.
REQ-018 ADDR: after address byte 3, go to COUNT; if address bits [1:0] != 0, go to ERROR instead.
REQ-019 COUNT: after count byte 1, go to DATA if N>0, else go to CHECK with the expected checksum 0x00.
REQ-020 The word index shall initialise to start address bits [ADDR_W+1:2]; higher address bits shall be ignored.
REQ-021 DATA: bytes shall assemble LSB first; mem_we shall pulse exactly one cycle, in the cycle after the 4th byte of a word is accepted, with mem_waddr/mem_wdata registered.
REQ-022 The word index shall increment by 1 after each write and wrap modulo 2^ADDR_W.
REQ-023 After the Nth word's 4th byte, the state shall go to CHECK.
REQ-024 CHECK: on the checksum byte, go to DONE if it matches the running XOR, else to ERROR.
REQ-025 in_ready shall be 1 in IDLE, ADDR, COUNT, DATA and CHECK, and 0 in DONE and ERROR.
REQ-026 in_valid=0 cycles shall stall the frame with no state change and no timeout.
REQ-027 busy shall be 1 in ADDR, COUNT, DATA and CHECK, and 0 otherwise.
REQ-028 done shall be 1 only in DONE; error shall be 1 only in ERROR.
REQ-029 clear shall move DONE or ERROR to IDLE in the next cycle and is ignored in all other states.
REQ-030 Words written before a checksum error shall not be rolled back; error only flags the frame.
REQ-031 mem_we shall never assert outside DATA-driven writes; mem_waddr/mem_wdata hold their last values when mem_we=0.

Reset
REQ-032 While reset_n=0, the state shall be IDLE and mem_we, busy, done, error, mem_waddr, mem_wdata, the checksum and the byte counters shall be 0; in_ready=1.
REQ-033 Reset asserted mid-frame shall abort immediately with no further mem_we; the next frame starts from IDLE.
REQ-034 Reset deassertion shall be synchronised internally so the first post-reset edge is safe.

Verification
REQ-035 Stream A0 0F 00 00 01 00 33 E2 62 00 B3 -> one mem_we, mem_waddr=1000, mem_wdata=0x0062E233, then done=1, error=0.
REQ-036 Same frame with last byte 0xB2 -> the word at 1000 is written, then error=1, done=0, in_ready=0 until clear.
REQ-037 Address bytes 02 00 00 00 -> error=1 after the 4th byte, no mem_we.
REQ-038 Count 00 00, checksum 00 -> done=1, no mem_we; checksum 01 -> error=1.
REQ-039 Start index 1023, N=2 with random in_valid gaps -> writes at 1023 then 0, data correct, done=1.
REQ-040 reset_n pulsed low after the 2nd data byte -> no mem_we, all outputs 0; a fresh valid frame then completes with done=1.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction-memory loader: parses an address/count/data/checksum byte stream
// and writes 32-bit little-endian words into instruction memory.
module imem_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              clear,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_COUNT, S_DATA, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [23:0]       addr_q, addr_d;
  logic [7:0]        cnt_lo_q, cnt_lo_d;
  logic [15:0]       rem_q, rem_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [23:0]       wbuf_q, wbuf_d;
  logic [7:0]        csum_q, csum_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic [1:0]        rst_sync_q;
  logic              rst_n_s;
  logic              xfer;
  logic [31:0]       full_addr;
  logic              unused_addr_bits;

  // Assert asynchronously, release two edges after reset_n rises
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n_s = rst_sync_q[1];

  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_q  <= S_IDLE;
      bcnt_q   <= 2'd0;
      addr_q   <= 24'd0;
      cnt_lo_q <= 8'd0;
      rem_q    <= 16'd0;
      idx_q    <= {ADDR_W{1'b0}};
      wbuf_q   <= 24'd0;
      csum_q   <= 8'd0;
      we_q     <= 1'b0;
      waddr_q  <= {ADDR_W{1'b0}};
      wdata_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      bcnt_q   <= bcnt_d;
      addr_q   <= addr_d;
      cnt_lo_q <= cnt_lo_d;
      rem_q    <= rem_d;
      idx_q    <= idx_d;
      wbuf_q   <= wbuf_d;
      csum_q   <= csum_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign xfer      = in_valid & in_ready;
  assign full_addr = {in_data, addr_q};
  // Address bits above the word index are deliberately ignored
  assign unused_addr_bits = ^full_addr[31:ADDR_W+2];

  always_comb begin
    state_d  = state_q;
    bcnt_d   = bcnt_q;
    addr_d   = addr_q;
    cnt_lo_d = cnt_lo_q;
    rem_d    = rem_q;
    idx_d    = idx_q;
    wbuf_d   = wbuf_q;
    csum_d   = csum_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          addr_d  = {16'd0, in_data};
          bcnt_d  = 2'd1;
          csum_d  = 8'd0;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (xfer) begin
          bcnt_d = bcnt_q + 2'd1;
          case (bcnt_q)
            2'd1:    addr_d[15:8]  = in_data;
            2'd2:    addr_d[23:16] = in_data;
            2'd3: begin
              if (addr_q[1:0] != 2'b00) begin
                state_d = S_ERROR;
              end else begin
                idx_d   = full_addr[ADDR_W+1:2];
                state_d = S_COUNT;
              end
            end
            default: addr_d[7:0]   = in_data;
          endcase
        end
      end
      S_COUNT: begin
        if (xfer) begin
          if (!bcnt_q[0]) begin
            cnt_lo_d = in_data;
            bcnt_d   = 2'd1;
          end else begin
            rem_d   = {in_data, cnt_lo_q};
            bcnt_d  = 2'd0;
            state_d = (rem_d == 16'd0) ? S_CHECK : S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          csum_d = csum_q ^ in_data;
          bcnt_d = bcnt_q + 2'd1;
          case (bcnt_q)
            2'd0: wbuf_d[7:0]   = in_data;
            2'd1: wbuf_d[15:8]  = in_data;
            2'd2: wbuf_d[23:16] = in_data;
            default: begin
              we_d    = 1'b1;
              waddr_d = idx_q;
              wdata_d = {in_data, wbuf_q};
              idx_d   = idx_q + 1'b1;
              rem_d   = rem_q - 16'd1;
              if (rem_q == 16'd1) state_d = S_CHECK;
            end
          endcase
        end
      end
      S_CHECK: begin
        if (xfer) state_d = (in_data == csum_q) ? S_DONE : S_ERROR;
      end
      S_DONE, S_ERROR: begin
        if (clear) begin
          state_d = S_IDLE;
          bcnt_d  = 2'd0;
          csum_d  = 8'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q != S_DONE) && (state_q != S_ERROR);
  assign busy      = (state_q == S_ADDR) || (state_q == S_COUNT) ||
                     (state_q == S_DATA) || (state_q == S_CHECK);
  assign done      = (state_q == S_DONE);
  assign error     = (state_q == S_ERROR);
  assign mem_we    = we_q;
  assign mem_waddr = waddr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: valid frames, checksum/alignment errors,
// empty frame, index wrap with stalls, and reset mid-frame.
module tb_imem_loader;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              clear;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  logic              busy;
  logic              done;
  logic              error;

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;
  int base;
  logic [ADDR_W-1:0] wa [64];
  logic [31:0]       wd [64];
  logic [7:0] fa [11] = '{8'hA0, 8'h0F, 8'h00, 8'h00, 8'h01, 8'h00,
                          8'h33, 8'hE2, 8'h62, 8'h00, 8'hB3};
  logic [7:0] fe [15] = '{8'hFC, 8'h0F, 8'h00, 8'h00, 8'h02, 8'h00,
                          8'h44, 8'h33, 8'h22, 8'h11,
                          8'h0F, 8'h0F, 8'hA5, 8'hA5, 8'h44};

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .clear(clear), .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Write monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wa[wr_cnt % 64] <= mem_waddr;
      wd[wr_cnt % 64] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_clear;
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  initial begin
    in_valid = 1'b0;
    in_data  = 8'h00;
    clear    = 1'b0;
    reset_n  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_waddr", mem_waddr, 0);
    chk("rst_wdata", mem_wdata, 0);
    reset_n = 1'b1;
    idle(4);

    // Frame A: one word at index 1000, good checksum; stall + ignored clear mid-frame
    base = wr_cnt;
    send(fa[0]);
    chk("A_busy_rise", busy, 1);
    for (int i = 1; i < 6; i++) send(fa[i]);
    do_clear;
    chk("A_clear_ignored", busy, 1);
    for (int i = 6; i < 11; i++) send(fa[i]);
    idle(2);
    chk("A_done", done, 1);
    chk("A_error", error, 0);
    chk("A_busy_fall", busy, 0);
    chk("A_in_ready", in_ready, 0);
    chk("A_nwr", wr_cnt - base, 1);
    chk("A_waddr", wa[base % 64], 1000);
    chk("A_wdata", wd[base % 64], 32'h0062E233);
    chk("A_we_low", mem_we, 0);
    chk("A_waddr_hold", mem_waddr, 1000);
    do_clear;
    chk("A_clr_done", done, 0);
    chk("A_clr_ready", in_ready, 1);

    // Frame B: bad checksum, word still written
    base = wr_cnt;
    for (int i = 0; i < 10; i++) send(fa[i]);
    send(8'hB2);
    idle(2);
    chk("B_nwr", wr_cnt - base, 1);
    chk("B_waddr", wa[base % 64], 1000);
    chk("B_error", error, 1);
    chk("B_done", done, 0);
    chk("B_in_ready", in_ready, 0);
    send(8'h00);
    chk("B_error_held", error, 1);
    do_clear;
    chk("B_clr_error", error, 0);

    // Frame C: misaligned start address
    base = wr_cnt;
    send(8'h02); send(8'h00); send(8'h00); send(8'h00);
    chk("C_error", error, 1);
    chk("C_busy", busy, 0);
    send(8'h01); send(8'h00);
    idle(2);
    chk("C_nwr", wr_cnt - base, 0);
    do_clear;

    // Frame D: empty frame, checksum 00 then 01
    base = wr_cnt;
    for (int i = 0; i < 7; i++) send(8'h00);
    idle(2);
    chk("D_done", done, 1);
    chk("D_nwr", wr_cnt - base, 0);
    do_clear;
    for (int i = 0; i < 6; i++) send(8'h00);
    send(8'h01);
    chk("D2_error", error, 1);
    chk("D2_done", done, 0);
    do_clear;

    // Frame E: index wrap 1023 -> 0 with valid gaps
    base = wr_cnt;
    for (int i = 0; i < 15; i++) begin
      idle($urandom_range(0, 3));
      send(fe[i]);
    end
    idle(2);
    chk("E_nwr", wr_cnt - base, 2);
    chk("E_waddr0", wa[base % 64], 1023);
    chk("E_wdata0", wd[base % 64], 32'h11223344);
    chk("E_waddr1", wa[(base + 1) % 64], 0);
    chk("E_wdata1", wd[(base + 1) % 64], 32'hA5A50F0F);
    chk("E_done", done, 1);
    do_clear;

    // Reset mid-frame after the second data byte, then a fresh frame
    base = wr_cnt;
    for (int i = 0; i < 8; i++) send(fa[i]);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("R_we", mem_we, 0);
    chk("R_busy", busy, 0);
    chk("R_done", done, 0);
    chk("R_error", error, 0);
    chk("R_wdata", mem_wdata, 0);
    chk("R_in_ready", in_ready, 1);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    idle(4);
    chk("R_nwr", wr_cnt - base, 0);
    for (int i = 0; i < 11; i++) send(fa[i]);
    idle(2);
    chk("R2_done", done, 1);
    chk("R2_nwr", wr_cnt - base, 1);
    chk("R2_wdata", wd[base % 64], 32'h0062E233);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
